// File: rtl/instr_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_decode: ID-stage front half. Classifies fetched instructions into   |
// | one-hot class strobes, registers fields, optional load-use bubble         |
// | (LOAD_USE_STALL_EN).                                                      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module instr_decode #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [XLEN-1:0]   if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_ready,
    input  logic              ex_ready,
    output logic              id_valid,
    output logic              load_store,
    output logic              alu_inm,
    output logic              branch,
    output logic              jump_abs,
    output logic              alu_reg,
    output logic              jump_rel,
    output logic              shift_var,
    output logic              shift,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [XLEN-1:0]   imm_ext,
    output logic [XLEN-1:0]   id_pc,
    output logic              illegal,
    output logic [CNT_W-1:0]  bubble_count
);

    logic [5:0]      w_op;
    logic [5:0]      w_fn;
    logic            w_ls, w_inm, w_br, w_ja, w_reg, w_jr, w_shv, w_sh;
    logic            w_ill;
    logic [3:0]      w_pc_top;
    logic [XLEN-1:0] w_imm;
    logic            w_adv;
    logic            w_hazard;
    logic            w_xfer;

    logic            r_valid;
    logic [7:0]      r_cls;
    logic            r_ill;
    logic [4:0]      r_rs, r_rt, r_rd, r_shamt;
    logic [XLEN-1:0] r_imm, r_pc;

    assign w_op = if_instr[31:26];
    assign w_fn = if_instr[5:0];

    always_comb begin
        w_ls  = 1'b0;
        w_inm = 1'b0;
        w_br  = 1'b0;
        w_ja  = 1'b0;
        w_reg = 1'b0;
        w_jr  = 1'b0;
        w_shv = 1'b0;
        w_sh  = 1'b0;
        w_ill = 1'b0;
        case (w_op)
            6'h00: begin
                case (w_fn)
                    6'h00, 6'h02, 6'h03: w_sh  = 1'b1;
                    6'h04, 6'h06, 6'h07: w_shv = 1'b1;
                    6'h08, 6'h09:        w_jr  = 1'b1;
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B:        w_reg = 1'b1;
                    default:             w_ill = 1'b1;
                endcase
            end
            6'h02, 6'h03:                      w_ja  = 1'b1;
            6'h04, 6'h05, 6'h06, 6'h07:        w_br  = 1'b1;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F:        w_inm = 1'b1;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
            6'h28, 6'h29, 6'h2B:               w_ls  = 1'b1;
            default:                           w_ill = 1'b1;
        endcase
    end

    // Top nibble of pc+4: the +4 carries into bit 28 only when pc[27:2] is all ones.
    assign w_pc_top = if_pc[31:28] + {3'b000, &if_pc[27:2]};

    always_comb begin
        if (w_ja) begin
            w_imm = {w_pc_top, if_instr[25:0], 2'b00};
        end else if (w_op == 6'h0C || w_op == 6'h0D || w_op == 6'h0E) begin
            w_imm = {16'h0000, if_instr[15:0]};
        end else if (w_op == 6'h0F) begin
            w_imm = {if_instr[15:0], 16'h0000};
        end else begin
            w_imm = {{16{if_instr[15]}}, if_instr[15:0]};
        end
    end

    assign w_adv    = ~r_valid | ex_ready;
    assign if_ready = rst_n & w_adv & ~w_hazard & ~flush;
    assign w_xfer   = if_valid & if_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_cls   <= '0;
            r_ill   <= 1'b0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_shamt <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_cls   <= {w_ls, w_inm, w_br, w_ja, w_reg, w_jr, w_shv, w_sh};
            r_ill   <= w_ill;
            r_rs    <= if_instr[25:21];
            r_rt    <= if_instr[20:16];
            r_rd    <= if_instr[15:11];
            r_shamt <= if_instr[10:6];
            r_imm   <= w_imm;
            r_pc    <= if_pc;
        end else if (flush | w_adv) begin
            // Bubble or kill: fields keep stale values, strobes go quiet.
            r_valid <= 1'b0;
            r_cls   <= '0;
            r_ill   <= 1'b0;
        end
    end

`ifdef LOAD_USE_STALL_EN
    localparam logic [0:0] c_RUN    = 1'b0;
    localparam logic [0:0] c_BUBBLE = 1'b1;

    logic [0:0]       r_state;
    logic             r_held_load;
    logic [CNT_W-1:0] r_count;
    logic             w_reads_rs;
    logic             w_reads_rt;

    assign w_reads_rs = w_reg | w_inm | w_ls | w_br | w_jr | w_shv;
    assign w_reads_rt = w_reg | w_sh | w_shv
                      | (w_op == 6'h28) | (w_op == 6'h29) | (w_op == 6'h2B)
                      | (w_op == 6'h04) | (w_op == 6'h05);

    assign w_hazard = (r_state == c_RUN) & r_valid & r_held_load & (r_rt != 5'd0) & if_valid
                    & ((w_reads_rs & (if_instr[25:21] == r_rt))
                     | (w_reads_rt & (if_instr[20:16] == r_rt)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_RUN;
            r_held_load <= 1'b0;
            r_count     <= '0;
        end else begin
            if (flush) begin
                r_state <= c_RUN;
            end else if (w_adv & w_hazard) begin
                r_state <= c_BUBBLE;
                if (r_count != {CNT_W{1'b1}}) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (w_xfer) begin
                r_state <= c_RUN;
            end
            if (w_xfer) begin
                r_held_load <= (w_op >= 6'h20) && (w_op <= 6'h25);
            end
        end
    end

    assign bubble_count = r_count;
`else
    assign w_hazard     = 1'b0;
    assign bubble_count = '0;
`endif

    assign id_valid = r_valid;
    assign {load_store, alu_inm, branch, jump_abs, alu_reg, jump_rel, shift_var, shift} = r_cls;
    assign illegal  = r_ill;
    assign rs       = r_rs;
    assign rt       = r_rt;
    assign rd       = r_rd;
    assign shamt    = r_shamt;
    assign imm_ext  = r_imm;
    assign id_pc    = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode.sv
`default_nettype none
// Bench for instr_decode: decode vector table, hand-written hazard/flush/backpressure
// sequences, then random traffic against a cycle-level reference model.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst_n, flush, if_valid, ex_ready, if_ready, id_valid;
    logic [31:0] if_instr, if_pc, imm_ext, id_pc;
    logic        load_store, alu_inm, branch, jump_abs, alu_reg, jump_rel, shift_var, shift;
    logic [4:0]  rs, rt, rd, shamt;
    logic        illegal;
    logic [15:0] bubble_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_bc   = 0;

`ifdef LOAD_USE_STALL_EN
    localparam int STALL = 1;
`else
    localparam int STALL = 0;
`endif

    instr_decode #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .ex_ready(ex_ready), .id_valid(id_valid),
        .load_store(load_store), .alu_inm(alu_inm), .branch(branch), .jump_abs(jump_abs),
        .alu_reg(alu_reg), .jump_rel(jump_rel), .shift_var(shift_var), .shift(shift),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm_ext(imm_ext), .id_pc(id_pc), .illegal(illegal), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Class vector order: load_store alu_inm branch jump_abs alu_reg jump_rel shift_var shift
    function automatic logic [7:0] ref_cls(input logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        logic [5:0] fn = ins[5:0];
        if (op == 6'h00) begin
            if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) return 8'h01;
            if (fn == 6'h04 || fn == 6'h06 || fn == 6'h07) return 8'h02;
            if (fn == 6'h08 || fn == 6'h09) return 8'h04;
            if ((fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2A || fn == 6'h2B) return 8'h08;
            return 8'h00;
        end
        if (op == 6'h02 || op == 6'h03) return 8'h10;
        if (op >= 6'h04 && op <= 6'h07) return 8'h20;
        if (op >= 6'h08 && op <= 6'h0F) return 8'h40;
        if (op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25 ||
            op == 6'h28 || op == 6'h29 || op == 6'h2B) return 8'h80;
        return 8'h00;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [31:0] pc);
        logic [31:0] nxt = pc + 32'd4;
        logic [5:0]  op  = ins[31:26];
        if (ref_cls(ins) == 8'h10) return {nxt[31:28], ins[25:0], 2'b00};
        if (op >= 6'h0C && op <= 6'h0E) return {16'h0, ins[15:0]};
        if (op == 6'h0F) return {ins[15:0], 16'h0};
        return {{16{ins[15]}}, ins[15:0]};
    endfunction

    function automatic bit ref_reads_rs(input logic [31:0] ins);
        return (ref_cls(ins) & 8'b1110_1110) != 8'h00;
    endfunction

    function automatic bit ref_reads_rt(input logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        return ((ref_cls(ins) & 8'b0000_1011) != 8'h00) ||
               op == 6'h28 || op == 6'h29 || op == 6'h2B || op == 6'h04 || op == 6'h05;
    endfunction

    function automatic logic [127:0] act_fields();
        return {id_valid, load_store, alu_inm, branch, jump_abs, alu_reg, jump_rel, shift_var,
                shift, illegal, rs, rt, rd, shamt, imm_ext, id_pc};
    endfunction

    function automatic logic [127:0] exp_fields(input logic [31:0] ins, input logic [31:0] pc);
        logic [7:0] c = ref_cls(ins);
        return {1'b1, c, (c == 8'h00), ins[25:21], ins[20:16], ins[15:11], ins[10:6],
                ref_imm(ins, pc), pc};
    endfunction

    task automatic check_fields(input string name, input logic [31:0] ins, input logic [31:0] pc);
        check(name, act_fields(), exp_fields(ins, pc));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  a  = 5'($urandom_range(0, 3));
        logic [4:0]  b  = 5'($urandom_range(0, 3));
        logic [4:0]  d  = 5'($urandom_range(0, 31));
        logic [15:0] im = 16'($urandom);
        logic [5:0]  fns [8] = '{6'h20, 6'h21, 6'h22, 6'h2A, 6'h00, 6'h04, 6'h08, 6'h01};
        case ($urandom_range(0, 5))
            0:       return {6'($urandom_range(32, 37)), a, b, im};
            1:       return {6'h00, a, b, d, 5'($urandom), fns[$urandom_range(0, 7)]};
            2:       return {6'h2B, a, b, im};
            3:       return {6'($urandom_range(4, 5)), a, b, im};
            4:       return {6'($urandom_range(8, 15)), a, b, im};
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [7:0]  cls;
        logic        ill;
        logic [31:0] imm;
    } vec_t;

    task automatic load_use(input string nm, input logic [31:0] ld, input logic [31:0] us,
                            input int exp_b);
        int zeros = 0;
        bit acc   = 1'b0;
        bit done  = 1'b0;
        @(negedge clk);
        flush = 0; ex_ready = 1; if_valid = 1; if_instr = ld; if_pc = 32'h100;
        #1 check({nm, "_ld_ready"}, if_ready, 1);
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk);
            if_valid = !acc; if_instr = us; if_pc = 32'h104;
            #1;
            if (id_valid && id_pc == 32'h104) done = 1'b1;
            else if (!id_valid) zeros++;
            if (if_valid && if_ready) acc = 1'b1;
        end
        check({nm, "_reached"}, done, 1);
        check({nm, "_bubbles"}, zeros, exp_b);
        if (done) check_fields({nm, "_use"}, us, 32'h104);
        exp_bc += exp_b;
        check({nm, "_count"}, bubble_count, exp_bc);
    endtask

    initial begin
        vec_t vecs [15];
        bit          mv;
        logic [31:0] m_instr, m_pc;
        bit          adv, haz, exp_rdy;

        vecs[0]  = '{32'h8C410004, 32'h00001000, 8'h80, 1'b0, 32'h00000004};
        vecs[1]  = '{32'h3C01FFFF, 32'h00001004, 8'h40, 1'b0, 32'hFFFF0000};
        vecs[2]  = '{32'h00031080, 32'h00001008, 8'h01, 1'b0, 32'h00001080};
        vecs[3]  = '{32'h00431004, 32'h0000100C, 8'h02, 1'b0, 32'h00001004};
        vecs[4]  = '{32'h03E00008, 32'h00001010, 8'h04, 1'b0, 32'h00000008};
        vecs[5]  = '{32'h0043082A, 32'h00001014, 8'h08, 1'b0, 32'h0000082A};
        vecs[6]  = '{32'h08000010, 32'h10000000, 8'h10, 1'b0, 32'h10000040};
        vecs[7]  = '{32'h0BFFFFFF, 32'hFFFFFFFC, 8'h10, 1'b0, 32'h0FFFFFFC};
        vecs[8]  = '{32'h10220003, 32'h00001018, 8'h20, 1'b0, 32'h00000003};
        vecs[9]  = '{32'h2042FFFF, 32'h0000101C, 8'h40, 1'b0, 32'hFFFFFFFF};
        vecs[10] = '{32'h3042FFFF, 32'h00001020, 8'h40, 1'b0, 32'h0000FFFF};
        vecs[11] = '{32'hAC410008, 32'h00001024, 8'h80, 1'b0, 32'h00000008};
        vecs[12] = '{32'hFC000000, 32'h00001028, 8'h00, 1'b1, 32'h00000000};
        vecs[13] = '{32'h00000001, 32'h0000102C, 8'h00, 1'b1, 32'h00000001};
        vecs[14] = '{32'h8C41FFF0, 32'h00001030, 8'h80, 1'b0, 32'hFFFFFFF0};

        // Reset held for two edges with fetch offering an instruction
        rst_n = 0; flush = 0; if_valid = 1; ex_ready = 1; if_instr = 32'h8C410004; if_pc = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1 check("reset_if_ready", if_ready, 0);
        end
        check("reset_state", {act_fields(), bubble_count}, 128'h0);
        @(negedge clk);
        rst_n = 1; if_valid = 0;

        foreach (vecs[i]) begin
            @(negedge clk);
            if_valid = 1; if_instr = vecs[i].instr; if_pc = vecs[i].pc; ex_ready = 1;
            #1 check("tbl_if_ready", if_ready, 1);
            @(negedge clk);
            if_valid = 0;
            #1 check($sformatf("tbl_vec%0d", i), act_fields(),
                     {1'b1, vecs[i].cls, vecs[i].ill, vecs[i].instr[25:21], vecs[i].instr[20:16],
                      vecs[i].instr[15:11], vecs[i].instr[10:6], vecs[i].imm, vecs[i].pc});
        end

        load_use("lu_r1", 32'h8C410000, 32'h00241820, STALL);
        load_use("lu_r0", 32'h8C400000, 32'h00041820, 0);

        // Backpressure: slt held while sub waits
        @(negedge clk);
        ex_ready = 1; if_valid = 1; if_instr = 32'h0043082A; if_pc = 32'h300;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ex_ready = 0; if_instr = 32'h00A62022; if_pc = 32'h304;
            #1 check("bp_if_ready", if_ready, 0);
            check("bp_hold", act_fields(), exp_fields(32'h0043082A, 32'h300));
        end
        @(negedge clk);
        ex_ready = 1;
        #1 check("bp_release_ready", if_ready, 1);
        check("bp_release_hold", act_fields(), exp_fields(32'h0043082A, 32'h300));
        @(negedge clk);
        if_valid = 0;
        #1 check("bp_next", act_fields(), exp_fields(32'h00A62022, 32'h304));
        @(negedge clk);
        #1 check("bp_no_dup", id_valid, 0);

        // Flush while the beq after a load sits in the bubble slot
        @(negedge clk);
        if_valid = 1; if_instr = 32'h8C410000; if_pc = 32'h200;
        #1 check("fl_ld_ready", if_ready, 1);
        @(negedge clk);
        if_instr = 32'h10220003; if_pc = 32'h204;
        #1 check("fl_beq_ready", if_ready, STALL == 0);
        @(negedge clk);
        flush = 1;
        #1 check("fl_ready_forced", if_ready, 0);
        @(negedge clk);
        flush = 0; if_instr = 32'h2042FFFF; if_pc = 32'h208;
        #1 check("fl_killed", {id_valid, illegal, branch}, 3'b000);
        check("fl_run_ready", if_ready, 1);
        @(negedge clk);
        if_valid = 0;
        #1 check_fields("fl_after", 32'h2042FFFF, 32'h208);
        exp_bc += STALL;
        check("fl_count", bubble_count, exp_bc);

        // Drain, then random traffic against the reference model
        @(negedge clk);
        ex_ready = 1; if_valid = 0;
        mv = 0; m_instr = 0; m_pc = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if_valid = ($urandom % 4) != 0;
            ex_ready = ($urandom % 4) != 0;
            flush    = ($urandom % 16) == 0;
            if_instr = rand_instr();
            if_pc    = $urandom & 32'hFFFF_FFFC;
            #1;
            adv = !mv || ex_ready;
            haz = (STALL != 0) && mv && m_instr[31:26] >= 6'h20 && m_instr[31:26] <= 6'h25 &&
                  m_instr[20:16] != 5'd0 && if_valid &&
                  ((ref_reads_rs(if_instr) && if_instr[25:21] == m_instr[20:16]) ||
                   (ref_reads_rt(if_instr) && if_instr[20:16] == m_instr[20:16]));
            exp_rdy = adv && !haz && !flush;
            check("rnd_if_ready", if_ready, exp_rdy);
            if (mv) check_fields("rnd_fields", m_instr, m_pc);
            else    check("rnd_idle", {id_valid, load_store, alu_inm, branch, jump_abs, alu_reg,
                                       jump_rel, shift_var, shift, illegal}, 10'h0);
            check("rnd_bubble_count", bubble_count, exp_bc);
            if (flush) begin
                mv = 0;
            end else if (if_valid && exp_rdy) begin
                mv = 1; m_instr = if_instr; m_pc = if_pc;
            end else if (adv) begin
                mv = 0;
                if (haz) exp_bc++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
